// File: rtl/executor_move_seq.sv
// Multi-step move executor: walks the active tile up to N cells (or until blocked),
// handshaking with the collision map after every written position.
package executor_move_seq_pkg;
    typedef enum logic [1:0] {
        eNonDir = 2'd0,
        eDown   = 2'd1,
        eLeft   = 2'd2,
        eRight  = 2'd3
    } direction_e;
endpackage

module executor_move_seq
    import executor_move_seq_pkg::*;
#(
    parameter  int width_p     = 16,
    parameter  int height_p    = 32,
    parameter  int max_steps_p = 15,
    localparam int x_w         = $clog2(width_p) + 1,
    localparam int y_w         = $clog2(height_p) + 1,
    localparam int pos_w       = x_w + y_w,
    localparam int steps_w     = $clog2(max_steps_p + 1),
    localparam int count_w     = $clog2(height_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  direction_e         direction_i,
    input  logic [steps_w-1:0] steps_i,
    input  logic               abort_i,
    input  logic [pos_w-1:0]   pos_i,
    input  logic [2:0]         move_avail_i,
    input  logic               cm_is_ready_i,
    output logic [pos_w-1:0]   new_pos_o,
    output logic               new_pos_v_o,
    output logic               done_o,
    output logic [count_w-1:0] steps_done_o,
    output logic               blocked_o
);

    // Positions travel as packed {x, y}.
    typedef struct packed {
        logic [x_w-1:0] x;
        logic [y_w-1:0] y;
    } point_t;

    typedef enum logic [2:0] {eIDLE, eCheck, eWrite, eWaiting, eDone} state_e;

    state_e             state_q, state_d;
    direction_e         dir_q, dir_d;
    point_t             pos_q, pos_d;
    logic [steps_w-1:0] remaining_q, remaining_d;
    logic               unlimited_q, unlimited_d;
    logic [count_w-1:0] count_q, count_d;
    logic               blocked_q, blocked_d;

    logic               avail;
    logic [count_w-1:0] limit;
    logic               exhausted;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (!reset_n_i) begin
            state_q     <= eIDLE;
            dir_q       <= eNonDir;
            pos_q       <= '0;
            remaining_q <= '0;
            unlimited_q <= 1'b0;
            count_q     <= '0;
            blocked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            remaining_q <= remaining_d;
            unlimited_q <= unlimited_d;
            count_q     <= count_d;
            blocked_q   <= blocked_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        remaining_d = remaining_q;
        unlimited_d = unlimited_q;
        count_d     = count_q;
        blocked_d   = blocked_q;
        avail       = 1'b0;
        limit       = count_w'(height_p);

        unique case (dir_q)
            eDown:   begin avail = move_avail_i[2]; limit = count_w'(height_p); end
            eLeft:   begin avail = move_avail_i[0]; limit = count_w'(width_p);  end
            eRight:  begin avail = move_avail_i[1]; limit = count_w'(width_p);  end
            default: begin avail = 1'b0;            limit = count_w'(height_p); end
        endcase

        // Unlimited runs stop at the playfield extent so a broken map cannot spin forever.
        exhausted = unlimited_q ? (count_q == limit) : (remaining_q == '0);

        unique case (state_q)
            eIDLE: begin
                if (v_i) begin
                    dir_d       = direction_i;
                    pos_d       = point_t'(pos_i);
                    remaining_d = steps_i;
                    unlimited_d = (steps_i == '0);
                    count_d     = '0;
                    blocked_d   = 1'b0;
                    state_d     = eCheck;
                end
            end
            eCheck: begin
                if (abort_i) begin
                    state_d = eDone;
                end else if (!avail) begin
                    blocked_d = (dir_q != eNonDir);
                    state_d   = eDone;
                end else if (exhausted) begin
                    state_d = eDone;
                end else begin
                    unique case (dir_q)
                        eDown:   pos_d.y = pos_q.y + y_w'(1);
                        eLeft:   pos_d.x = pos_q.x - x_w'(1);
                        eRight:  pos_d.x = pos_q.x + x_w'(1);
                        default: pos_d   = pos_q;
                    endcase
                    count_d = count_q + count_w'(1);
                    if (!unlimited_q) remaining_d = remaining_q - steps_w'(1);
                    state_d = eWrite;
                end
            end
            eWrite:   state_d = eWaiting;
            eWaiting: if (cm_is_ready_i) state_d = eCheck;
            eDone:    state_d = eIDLE;
            default:  state_d = eIDLE;
        endcase
    end

    assign ready_o      = (state_q == eIDLE);
    assign new_pos_v_o  = (state_q == eWrite);
    assign done_o       = (state_q == eDone);
    assign new_pos_o    = pos_q;
    assign steps_done_o = count_q;
    assign blocked_o    = blocked_q;

endmodule

// File: tb/tb_executor_move_seq.sv
// Directed bench for executor_move_seq: a small collision-map model answers each write,
// and each scenario task checks strobe positions, cycle timing and completion status.
module tb_executor_move_seq;
    import executor_move_seq_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        v_i = 1'b0;
    logic        ready_o;
    direction_e  direction_i = eNonDir;
    logic [3:0]  steps_i = '0;
    logic        abort_i = 1'b0;
    logic [10:0] pos_i = '0;
    logic [2:0]  move_avail_i = '0;
    logic        cm_is_ready_i = 1'b1;
    logic [10:0] new_pos_o;
    logic        new_pos_v_o;
    logic        done_o;
    logic [5:0]  steps_done_o;
    logic        blocked_o;

    executor_move_seq dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
        .direction_i(direction_i), .steps_i(steps_i), .abort_i(abort_i), .pos_i(pos_i),
        .move_avail_i(move_avail_i), .cm_is_ready_i(cm_is_ready_i),
        .new_pos_o(new_pos_o), .new_pos_v_o(new_pos_v_o), .done_o(done_o),
        .steps_done_o(steps_done_o), .blocked_o(blocked_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Scenario knobs, written only by the stimulus process.
    logic [2:0] avail_base = 3'b111;
    int         down_limit = 1000;
    int         cm_delay   = 0;
    int         acc_cyc    = 0;

    // Observations, written only by the monitor.
    logic [10:0] strobes[$];
    int          strobe_rel[$];
    int          done_seen = 0;
    int          done_rel = -1;
    int          done_steps = -1;
    logic        done_blocked = 1'b0;
    int          wait_cnt = 0;

    // Collision-map model plus output monitor, all away from the active edge.
    always @(negedge clk_i) begin
        if (new_pos_v_o) begin
            strobes.push_back(new_pos_o);
            strobe_rel.push_back(cyc - acc_cyc);
            wait_cnt = cm_delay;
        end else if (wait_cnt > 0) begin
            wait_cnt = wait_cnt - 1;
        end
        cm_is_ready_i = (wait_cnt == 0);
        if (done_o) begin
            done_seen    = done_seen + 1;
            done_rel     = cyc - acc_cyc;
            done_steps   = int'(steps_done_o);
            done_blocked = blocked_o;
        end
        move_avail_i = {avail_base[2] && (strobes.size() < down_limit), avail_base[1:0]};
    end

    int n_pass = 0;
    int n_total = 0;
    int s_base = 0;
    int d_base = 0;

    function automatic logic [10:0] mk(input int x, input int y);
        return {5'(x), 6'(y)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_req(input direction_e d, input int steps, input int x, input int y);
        s_base      = strobes.size();
        d_base      = done_seen;
        acc_cyc     = cyc;
        v_i         = 1'b1;
        direction_i = d;
        steps_i     = 4'(steps);
        pos_i       = mk(x, y);
        tick();
        v_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_seen == d_base && n < budget) begin
            tick();
            n++;
        end
        n_total++;
        if (done_seen == d_base) $display("FAIL %s_timeout: no done_o within %0d cycles", name, budget);
        else n_pass++;
    endtask

    task automatic wait_strobes(input string name, input int cnt, input int budget);
        int n;
        n = 0;
        while (strobes.size() - s_base < cnt && n < budget) begin
            tick();
            n++;
        end
        n_total++;
        if (strobes.size() - s_base < cnt) $display("FAIL %s_strobe_timeout: saw %0d strobes, need %0d", name, strobes.size() - s_base, cnt);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        repeat (3) tick();
        n_total++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else n_pass++;
        n_total++; if (new_pos_v_o !== 1'b0) $display("FAIL reset_strobe: got %b want 0", new_pos_v_o); else n_pass++;
        n_total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else n_pass++;
        n_total++; if (new_pos_o !== 11'd0) $display("FAIL reset_pos: got %h want 0", new_pos_o); else n_pass++;
        n_total++; if (steps_done_o !== 6'd0) $display("FAIL reset_steps: got %0d want 0", steps_done_o); else n_pass++;
        n_total++; if (blocked_o !== 1'b0) $display("FAIL reset_blocked: got %b want 0", blocked_o); else n_pass++;
        reset_n_i = 1'b1;
        tick();
    endtask

    task automatic test_single_right();
        avail_base = 3'b010; down_limit = 1000; cm_delay = 0;
        do_req(eRight, 1, 3, 5);
        wait_done("single", 40);
        n_total++; if (strobes.size() - s_base !== 1) $display("FAIL single_strobe_count: got %0d want 1", strobes.size() - s_base); else n_pass++;
        if (strobes.size() > s_base) begin
            n_total++; if (strobes[s_base] !== mk(4, 5)) $display("FAIL single_pos: got %h want %h", strobes[s_base], mk(4, 5)); else n_pass++;
            n_total++; if (strobe_rel[s_base] !== 2) $display("FAIL single_strobe_cycle: got %0d want 2", strobe_rel[s_base]); else n_pass++;
        end
        n_total++; if (done_rel !== 5) $display("FAIL single_done_cycle: got %0d want 5", done_rel); else n_pass++;
        n_total++; if (done_steps !== 1) $display("FAIL single_steps: got %0d want 1", done_steps); else n_pass++;
        n_total++; if (done_blocked !== 1'b0) $display("FAIL single_blocked: got %b want 0", done_blocked); else n_pass++;
        repeat (3) tick();
        n_total++; if (steps_done_o !== 6'd1) $display("FAIL single_steps_hold: got %0d want 1", steps_done_o); else n_pass++;
    endtask

    task automatic test_hard_drop();
        avail_base = 3'b100; cm_delay = 0;
        down_limit = strobes.size() + 6;
        do_req(eDown, 0, 4, 0);
        wait_done("drop", 100);
        n_total++; if (strobes.size() - s_base !== 6) $display("FAIL drop_strobe_count: got %0d want 6", strobes.size() - s_base); else n_pass++;
        for (int i = 0; i < 6 && s_base + i < strobes.size(); i++) begin
            n_total++;
            if (strobes[s_base + i] !== mk(4, i + 1)) $display("FAIL drop_pos%0d: got %h want %h", i, strobes[s_base + i], mk(4, i + 1));
            else n_pass++;
        end
        n_total++; if (done_rel !== 20) $display("FAIL drop_done_cycle: got %0d want 20", done_rel); else n_pass++;
        n_total++; if (done_steps !== 6) $display("FAIL drop_steps: got %0d want 6", done_steps); else n_pass++;
        n_total++; if (done_blocked !== 1'b1) $display("FAIL drop_blocked: got %b want 1", done_blocked); else n_pass++;
        down_limit = 1000;
        tick();
    endtask

    task automatic test_blocked();
        avail_base = 3'b110; cm_delay = 0;
        do_req(eLeft, 3, 7, 9);
        wait_done("blocked", 20);
        n_total++; if (ready_o !== 1'b1) $display("FAIL blocked_ready_after_done: got %b want 1", ready_o); else n_pass++;
        n_total++; if (strobes.size() - s_base !== 0) $display("FAIL blocked_strobe_count: got %0d want 0", strobes.size() - s_base); else n_pass++;
        n_total++; if (done_rel !== 2) $display("FAIL blocked_done_cycle: got %0d want 2", done_rel); else n_pass++;
        n_total++; if (done_steps !== 0) $display("FAIL blocked_steps: got %0d want 0", done_steps); else n_pass++;
        n_total++; if (done_blocked !== 1'b1) $display("FAIL blocked_flag: got %b want 1", done_blocked); else n_pass++;
    endtask

    // Issued in the very cycle ready_o returns after the blocked request.
    task automatic test_back_to_back_nondir();
        avail_base = 3'b111; cm_delay = 0;
        do_req(eNonDir, 4, 1, 1);
        wait_done("nondir", 20);
        n_total++; if (strobes.size() - s_base !== 0) $display("FAIL nondir_strobe_count: got %0d want 0", strobes.size() - s_base); else n_pass++;
        n_total++; if (done_rel !== 2) $display("FAIL nondir_done_cycle: got %0d want 2", done_rel); else n_pass++;
        n_total++; if (done_steps !== 0) $display("FAIL nondir_steps: got %0d want 0", done_steps); else n_pass++;
        n_total++; if (done_blocked !== 1'b0) $display("FAIL nondir_blocked: got %b want 0", done_blocked); else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        avail_base = 3'b100; down_limit = 1000; cm_delay = 4;
        do_req(eDown, 10, 2, 3);
        wait_strobes("abort", 2, 60);
        abort_i = 1'b1;
        wait_done("abort", 60);
        abort_i = 1'b0;
        n_total++; if (strobes.size() - s_base !== 2) $display("FAIL abort_strobe_count: got %0d want 2", strobes.size() - s_base); else n_pass++;
        n_total++; if (done_rel !== 14) $display("FAIL abort_done_cycle: got %0d want 14", done_rel); else n_pass++;
        n_total++; if (done_steps !== 2) $display("FAIL abort_steps: got %0d want 2", done_steps); else n_pass++;
        n_total++; if (done_blocked !== 1'b0) $display("FAIL abort_blocked: got %b want 0", done_blocked); else n_pass++;
        cm_delay = 0;
        repeat (6) tick();
    endtask

    task automatic test_unlimited_cap();
        avail_base = 3'b010; cm_delay = 0;
        do_req(eRight, 0, 20, 7);
        wait_done("cap", 200);
        n_total++; if (strobes.size() - s_base !== 16) $display("FAIL cap_strobe_count: got %0d want 16", strobes.size() - s_base); else n_pass++;
        if (strobes.size() - s_base >= 16) begin
            n_total++; if (strobes[s_base + 11] !== mk(0, 7)) $display("FAIL cap_wrap_pos: got %h want %h", strobes[s_base + 11], mk(0, 7)); else n_pass++;
            n_total++; if (strobes[s_base + 15] !== mk(4, 7)) $display("FAIL cap_last_pos: got %h want %h", strobes[s_base + 15], mk(4, 7)); else n_pass++;
        end
        n_total++; if (done_rel !== 50) $display("FAIL cap_done_cycle: got %0d want 50", done_rel); else n_pass++;
        n_total++; if (done_steps !== 16) $display("FAIL cap_steps: got %0d want 16", done_steps); else n_pass++;
        n_total++; if (done_blocked !== 1'b0) $display("FAIL cap_blocked: got %b want 0", done_blocked); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        avail_base = 3'b100; down_limit = 1000; cm_delay = 4;
        do_req(eDown, 5, 6, 2);
        wait_strobes("rstmid", 1, 20);
        reset_n_i = 1'b0;
        tick();
        n_total++; if (ready_o !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", ready_o); else n_pass++;
        n_total++; if (new_pos_o !== 11'd0) $display("FAIL rstmid_pos: got %h want 0", new_pos_o); else n_pass++;
        n_total++; if (steps_done_o !== 6'd0) $display("FAIL rstmid_steps: got %0d want 0", steps_done_o); else n_pass++;
        n_total++; if (blocked_o !== 1'b0) $display("FAIL rstmid_blocked: got %b want 0", blocked_o); else n_pass++;
        n_total++; if (new_pos_v_o !== 1'b0) $display("FAIL rstmid_strobe: got %b want 0", new_pos_v_o); else n_pass++;
        reset_n_i = 1'b1;
        cm_delay = 0;
        repeat (8) tick();
        n_total++; if (done_seen !== d_base) $display("FAIL rstmid_no_done: got %0d done pulses want 0", done_seen - d_base); else n_pass++;
        n_total++; if (strobes.size() - s_base !== 1) $display("FAIL rstmid_no_more_strobes: got %0d want 1", strobes.size() - s_base); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_right();
        test_hard_drop();
        test_blocked();
        test_back_to_back_nondir();
        test_abort();
        test_unlimited_cap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
